// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if
// ----------------
// Bundle of every signal between alu_share_arb and its neighbours: two
// requesters, two response consumers and the shared combinational ALU.
//
// Handshake rules for every valid/ready pair in this bundle:
// - A transfer happens on a rising clk edge where valid && ready are both high.
// - The source holds valid and its payload stable until that edge.
// - The source may drop valid before a transfer. The request is then
//   withdrawn with no side effects.
// - ready may depend combinationally on valid.
//
// Parameter:
//   XLEN - operand/result width.
//
// Modports:
//   slave  - the arbiter.
//            Inputs: requests, response ready, ALU result.
//            Outputs: request ready, responses, ALU drive.
//   master - the surroundings: requesters, consumers and the ALU (mirror of slave).
interface alu_share_arb_if #(
  parameter int XLEN = 32
);
  // requester 0
  logic            req0_valid;
  logic            req0_ready;
  logic [3:0]      req0_ctl;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  // requester 1
  logic            req1_valid;
  logic            req1_ready;
  logic [3:0]      req1_ctl;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  // response 0
  logic            resp0_valid;
  logic            resp0_ready;
  logic [XLEN-1:0] resp0_data;
  logic            resp0_zero;
  logic            resp0_err;
  // response 1
  logic            resp1_valid;
  logic            resp1_ready;
  logic [XLEN-1:0] resp1_data;
  logic            resp1_zero;
  logic            resp1_err;
  // shared ALU
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    output req1_ready,
    output resp0_valid, resp0_data, resp0_zero, resp0_err,
    input  resp0_ready,
    output resp1_valid, resp1_data, resp1_zero, resp1_err,
    input  resp1_ready,
    output alu_ctl, alu_a, alu_b,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b,
    input  req1_ready,
    input  resp0_valid, resp0_data, resp0_zero, resp0_err,
    output resp0_ready,
    input  resp1_valid, resp1_data, resp1_zero, resp1_err,
    output resp1_ready,
    input  alu_ctl, alu_a, alu_b,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb
// -------------
// Time-shares one combinational ALU between two requesters. At most one
// request is granted per cycle. The granted request drives the ALU, and the
// ALU output is captured into that requester's response register on the same
// edge. A response is therefore valid from the cycle after the grant.
//
// Parameter:
//   XLEN - operand/result width (must match the interface).
//
// Ports:
//   clk - rising-edge clock.
//   rst - asynchronous, active-high reset.
//   bus - alu_share_arb_if.slave. It carries:
//         - two request channels: valid/ready/ctl/a/b;
//         - two response channels: valid/ready/data/zero/err;
//         - the shared ALU drive (alu_ctl/alu_a/alu_b) and its return
//           (alu_result/alu_zero).
//
// Build option:
//   ALU_SHARE_ARB_FIXED_PRIO_EN
//     Defined: req0 always wins a tie, and no turn pointer exists.
//     Undefined (default): round-robin with a 1-bit last_grant pointer.
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  alu_share_arb_if.slave bus
);

  // Legal ALU control codes. Every other code is rejected with err set.
  localparam logic [3:0] CTL_ADD = 4'b0000;
  localparam logic [3:0] CTL_SUB = 4'b0001;
  localparam logic [3:0] CTL_SLT = 4'b0010;
  localparam logic [3:0] CTL_OR  = 4'b0011;
  localparam logic [3:0] CTL_AND = 4'b0100;
  localparam logic [3:0] CTL_CTZ = 4'b1111;

  function automatic logic is_legal(input logic [3:0] ctl);
    logic ok;
    ok = 1'b0;
    case (ctl)
      CTL_ADD, CTL_SUB, CTL_SLT, CTL_OR, CTL_AND, CTL_CTZ: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Response registers
  logic            resp0_valid_q;
  logic [XLEN-1:0] resp0_data_q;
  logic            resp0_zero_q;
  logic            resp0_err_q;
  logic            resp1_valid_q;
  logic [XLEN-1:0] resp1_data_q;
  logic            resp1_zero_q;
  logic            resp1_err_q;

  // Request decode
  logic legal0;
  logic legal1;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  assign legal0 = is_legal(bus.req0_ctl);
  assign legal1 = is_legal(bus.req1_ctl);

  // A requester may be granted only when its response slot is free. A slot
  // being drained this cycle counts as free, which keeps one operation per
  // cycle per requester while the consumer holds ready high.
  assign elig0 = bus.req0_valid && (!resp0_valid_q || bus.resp0_ready);
  assign elig1 = bus.req1_valid && (!resp1_valid_q || bus.resp1_ready);

  // Arbitration. Grants are suppressed while rst is high, so nothing can be
  // granted before the first edge after rst is released.
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = elig0;
      grant1 = elig1 && !elig0;
    end
  end
`else
  // last_grant holds the index of the most recent winner. On a tie the other
  // requester wins. The reset value of 1 lets req0 take the first tie.
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      last_grant <= grant1;
    end
  end
`endif

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Shared ALU drive. The ALU is driven with ADD and zero operands in two
  // cases: when nothing is granted, and when the granted code is illegal.
  // The ALU is therefore never exercised with a code it does not implement.
  always_comb begin
    bus.alu_ctl = CTL_ADD;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    if (grant0 && legal0) begin
      bus.alu_ctl = bus.req0_ctl;
      bus.alu_a   = bus.req0_a;
      bus.alu_b   = bus.req0_b;
    end else if (grant1 && legal1) begin
      bus.alu_ctl = bus.req1_ctl;
      bus.alu_a   = bus.req1_a;
      bus.alu_b   = bus.req1_b;
    end
  end

  // Response slot 0.
  // - A grant always wins over a drain, so a simultaneous drain and grant
  //   leaves valid high with the new result.
  // - A drain clears only valid. The payload fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp0_zero_q  <= 1'b0;
      resp0_err_q   <= 1'b0;
    end else if (grant0) begin
      resp0_valid_q <= 1'b1;
      if (legal0) begin
        resp0_data_q <= bus.alu_result;
        resp0_zero_q <= bus.alu_zero;
        resp0_err_q  <= 1'b0;
      end else begin
        resp0_data_q <= '0;
        resp0_zero_q <= 1'b0;
        resp0_err_q  <= 1'b1;
      end
    end else if (resp0_valid_q && bus.resp0_ready) begin
      resp0_valid_q <= 1'b0;
    end
  end

  // Response slot 1, same rules as slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp1_valid_q <= 1'b0;
      resp1_data_q  <= '0;
      resp1_zero_q  <= 1'b0;
      resp1_err_q   <= 1'b0;
    end else if (grant1) begin
      resp1_valid_q <= 1'b1;
      if (legal1) begin
        resp1_data_q <= bus.alu_result;
        resp1_zero_q <= bus.alu_zero;
        resp1_err_q  <= 1'b0;
      end else begin
        resp1_data_q <= '0;
        resp1_zero_q <= 1'b0;
        resp1_err_q  <= 1'b1;
      end
    end else if (resp1_valid_q && bus.resp1_ready) begin
      resp1_valid_q <= 1'b0;
    end
  end

  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp0_data  = resp0_data_q;
  assign bus.resp0_zero  = resp0_zero_q;
  assign bus.resp0_err   = resp0_err_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp1_data  = resp1_data_q;
  assign bus.resp1_zero  = resp1_zero_q;
  assign bus.resp1_err   = resp1_err_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer that time-shares the core's single combinational ALU. Each requester presents an ALU control code and two operands through a valid/ready handshake. The block grants at most one request per cycle, drives the shared ALU, and captures the result into a per-requester response register. It sits between the ALU control decoder and any secondary ALU user, such as a multi-cycle helper or debug unit, and the ALU itself.

## Interface
Parameters:
- XLEN, 32, operand/result width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant)
- req0_ctl / req1_ctl  in  4  ALU control code
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
- resp0_valid / resp1_valid  out  1  response held
- resp0_ready / resp1_ready  in  1  consumer takes response
- resp0_data / resp1_data  out  XLEN  captured ALU result
- resp0_zero / resp1_zero  out  1  captured ALU zero flag
- resp0_err / resp1_err  out  1  request carried an illegal control code
- alu_ctl  out  4  to shared ALU
- alu_a, alu_b  out  XLEN  to shared ALU
- alu_result  in  XLEN  from shared ALU (combinational)
- alu_zero  in  1  from shared ALU

## Operation
- Legal codes: 0000 ADD, 0001 SUB, 0010 SLT, 0011 OR, 0100 AND, 1111 CTZ. All other codes are illegal.
- Eligibility: requester i is eligible when reqi_valid && (!respi_valid || respi_ready). A draining response frees the slot in the same cycle.
- Arbitration: round-robin with a 1-bit last_grant pointer.
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - last_grant updates to the granted index on every grant.
- reqi_ready = granti. At most one grant per cycle.
- ALU drive:
  - With a grant: alu_ctl, alu_a, alu_b = the granted requester's fields.
  - No grant: alu_ctl=0000, alu_a=0, alu_b=0.
- Capture: on a clock edge with granti:
  - respi_data <= alu_result, respi_zero <= alu_zero, respi_err <= 0, respi_valid <= 1.
- Illegal code:
  - Still granted (consumes the slot and the arbitration turn).
  - ALU driven with 0000 and zero operands.
  - Capture: respi_data <= 0, respi_zero <= 0, respi_err <= 1.
- Drain: respi_valid && respi_ready with no new grant for i → respi_valid <= 0. The data, zero and err fields hold their last values.
- Simultaneous drain and grant for the same requester: the new result overwrites and respi_valid stays 1.
- The response fields are stable while respi_valid && !respi_ready.

## Timing
- Reset values (asynchronous, immediate on rst):
  - resp*_valid=0, resp*_data=0, resp*_zero=0, resp*_err=0.
  - last_grant=1, so req0 wins the first tie.
- With rst high, req*_ready=0 and the ALU drive is 0.
- Latency: grant in cycle N → respi_valid high from cycle N+1.
- Throughput: one operation per cycle total. Each requester sustains one per cycle only if its consumer holds respi_ready high.
- Handshake: reqi_valid must hold its fields until reqi_ready. Dropping valid before the grant withdraws the request with no side effects.
- Reset asserted mid-operation: pending responses are discarded. No grant is issued until the first edge after rst deasserts.

## Configuration
- ALU_SHARE_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, req0 always wins ties, and last_grant is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Single request: req0 ctl=0000, a=5, b=7 → req0_ready same cycle. Next cycle resp0_valid=1, resp0_data=12, resp0_zero=0.
- Tie after reset: both valid. req0 ctl=0001 a=9 b=9; req1 ctl=0011 a=0xF0 b=0x0F.
  - Cycle 0: grant req0. Cycle 1: grant req1.
  - resp0_data=0, resp0_zero=1. resp1_data=0xFF.
  - With FIXED_PRIO_EN and req0 still valid, req1 starves.
- Back-pressure: resp1_ready=0 with resp1_valid=1 and req1 valid → req1_ready=0 and resp1_data held. Raising resp1_ready → grant in the same cycle and new data on the next cycle.
- Illegal code: req0 ctl=0101 → alu_ctl=0000. Next cycle resp0_valid=1, resp0_err=1, resp0_data=0.
- CTZ: req1 ctl=1111, a=0x00000080, with the bench ALU model returning 7 → resp1_data=7, resp1_err=0.
- Reset mid-flight: assert rst while resp0_valid=1 → resp0_valid=0 immediately. After release, the first tie grants req0.
